// File: rtl/nes_bus_pkg.sv
// Shared address map and constants for the NES CPU-bus responder.
package nes_bus_pkg;

  localparam logic [15:0] RAM_BASE  = 16'h0000;
  localparam logic [15:0] RAM_LIMIT = 16'h1FFF;
  localparam logic [15:0] PPU_BASE  = 16'h2000;
  localparam logic [15:0] PPU_LIMIT = 16'h3FFF;
  localparam logic [15:0] JOY1_ADDR = 16'h4016;

  localparam logic [2:0] PPU_CTRL   = 3'd0;
  localparam logic [2:0] PPU_STATUS = 3'd2;
  localparam logic [2:0] PPU_ADDR   = 3'd6;
  localparam logic [2:0] PPU_DATA   = 3'd7;

  localparam logic [7:0] OPEN_BUS = 8'h40;

  typedef enum logic [1:0] {RegNone, RegRam, RegPpu, RegJoy} region_e;

  function automatic region_e decode_region(input logic [15:0] addr);
    if (addr <= RAM_LIMIT) return RegRam;
    if (addr >= PPU_BASE && addr <= PPU_LIMIT) return RegPpu;
    if (addr == JOY1_ADDR) return RegJoy;
    return RegNone;
  endfunction

endpackage

// File: rtl/nes_joypad.sv
// Controller port: strobe latch and serial shift register for the pad buttons.
module nes_joypad (
  input  logic       clk,
  input  logic       rst,
  input  logic       strobe_wr,
  input  logic       strobe_bit,
  input  logic       shift_rd,
  input  logic [7:0] key,
  output logic       data_bit
);

  logic       strobe_q;
  logic [7:0] shift_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      strobe_q <= 1'b0;
      shift_q  <= 8'h00;
    end else begin
      if (strobe_wr) strobe_q <= strobe_bit;
      // Reload uses the strobe value already latched, so a 1-then-0 write pair captures key.
      if (strobe_q) shift_q <= key;
      else if (shift_rd) shift_q <= {1'b1, shift_q[7:1]};
    end
  end

  assign data_bit = shift_q[0];

endmodule

// File: rtl/nes_bus_responder.sv
// CPU-bus slave for work RAM, a minimal PPU register file and controller port 1.
module nes_bus_responder
  import nes_bus_pkg::*;
#(
  parameter int unsigned RAM_AW = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [7:0]  avs_writedata,
  output logic [7:0]  avs_readdata,
  output logic        avs_readdatavalid,
  output logic        avs_waitrequest,
  input  logic [7:0]  key,
  input  logic        vblank_set,
  output logic        vram_wr_en,
  output logic [13:0] vram_wr_addr,
  output logic [7:0]  vram_wr_data,
  output logic        nmi
);

  logic        first_q, active, rd_acc, wr_acc, ram_we, joy_bit;
  region_e     region;
  logic [2:0]  reg_sel;
  logic [7:0]  ctrl_q, ctrl_d, reg_rd_q, reg_rdata, ram_rd_q;
  logic        vblank_q, vblank_d, toggle_q, toggle_d, vram_we_d;
  logic        rdv_q, ram_sel_q, nmi_q, vram_wr_en_q;
  logic [13:0] vaddr_q, vaddr_d, vram_wr_addr_q;
  logic [7:0]  vram_wr_data_q;
  logic [7:0]  mem [0:(1 << RAM_AW) - 1];

  // The cycle right after reset is treated as idle.
  assign active  = ~first_q;
  assign rd_acc  = active & avs_read;
  assign wr_acc  = active & avs_write & ~avs_read;
  assign region  = decode_region(avs_address);
  assign reg_sel = avs_address[2:0];
  assign ram_we  = wr_acc & (region == RegRam);

  always_ff @(posedge clk) begin
    if (ram_we) mem[avs_address[RAM_AW-1:0]] <= avs_writedata;
    ram_rd_q <= mem[avs_address[RAM_AW-1:0]];
  end

  nes_joypad u_joypad (
    .clk        (clk),
    .rst        (rst),
    .strobe_wr  (wr_acc & (region == RegJoy)),
    .strobe_bit (avs_writedata[0]),
    .shift_rd   (rd_acc & (region == RegJoy)),
    .key        (key),
    .data_bit   (joy_bit)
  );

  always_comb begin
    ctrl_d    = ctrl_q;
    vblank_d  = vblank_q;
    toggle_d  = toggle_q;
    vaddr_d   = vaddr_q;
    reg_rdata = 8'h00;
    vram_we_d = 1'b0;
    if (rd_acc) begin
      unique case (region)
        RegPpu: begin
          if (reg_sel == PPU_STATUS) begin
            reg_rdata = {vblank_q, 7'b0};
            vblank_d  = 1'b0;
            toggle_d  = 1'b0;
          end
        end
        RegJoy:  reg_rdata = OPEN_BUS | {7'b0, joy_bit};
        default: ;
      endcase
    end
    if (wr_acc && region == RegPpu) begin
      case (reg_sel)
        PPU_CTRL: ctrl_d = avs_writedata;
        PPU_ADDR: begin
          if (!toggle_q) vaddr_d[13:8] = avs_writedata[5:0];
          else vaddr_d[7:0] = avs_writedata;
          toggle_d = ~toggle_q;
        end
        PPU_DATA: begin
          vram_we_d = 1'b1;
          vaddr_d   = vaddr_q + (ctrl_q[2] ? 14'd32 : 14'd1);
        end
        default: ;
      endcase
    end
    // A coinciding vblank start wins over the STATUS read-clear.
    if (active && vblank_set) vblank_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    first_q <= rst;
    if (rst) begin
      ctrl_q         <= 8'h00;
      vblank_q       <= 1'b0;
      toggle_q       <= 1'b0;
      vaddr_q        <= 14'h0000;
      nmi_q          <= 1'b0;
      rdv_q          <= 1'b0;
      ram_sel_q      <= 1'b0;
      reg_rd_q       <= 8'h00;
      vram_wr_en_q   <= 1'b0;
      vram_wr_addr_q <= 14'h0000;
      vram_wr_data_q <= 8'h00;
    end else begin
      ctrl_q       <= ctrl_d;
      vblank_q     <= vblank_d;
      toggle_q     <= toggle_d;
      vaddr_q      <= vaddr_d;
      nmi_q        <= vblank_d & ctrl_d[7];
      rdv_q        <= rd_acc;
      ram_sel_q    <= (region == RegRam);
      reg_rd_q     <= reg_rdata;
      vram_wr_en_q <= vram_we_d;
      if (vram_we_d) begin
        vram_wr_addr_q <= vaddr_q;
        vram_wr_data_q <= avs_writedata;
      end
    end
  end

  assign avs_readdata      = rdv_q ? (ram_sel_q ? ram_rd_q : reg_rd_q) : 8'h00;
  assign avs_readdatavalid = rdv_q;
  assign avs_waitrequest   = 1'b0;
  assign vram_wr_en        = vram_wr_en_q;
  assign vram_wr_addr      = vram_wr_addr_q;
  assign vram_wr_data      = vram_wr_data_q;
  assign nmi               = nmi_q;

endmodule

// File: tb/tb_nes_bus_responder.sv
// Directed self-checking bench for nes_bus_responder.
module tb_nes_bus_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] avs_address;
  logic        avs_read, avs_write;
  logic [7:0]  avs_writedata, avs_readdata;
  logic        avs_readdatavalid, avs_waitrequest;
  logic [7:0]  key;
  logic        vblank_set;
  logic        vram_wr_en;
  logic [13:0] vram_wr_addr;
  logic [7:0]  vram_wr_data;
  logic        nmi;

  int n_cmp  = 0;
  int n_fail = 0;

  nes_bus_responder #(.RAM_AW(11)) dut (
    .clk               (clk),
    .rst               (rst),
    .avs_address       (avs_address),
    .avs_read          (avs_read),
    .avs_write         (avs_write),
    .avs_writedata     (avs_writedata),
    .avs_readdata      (avs_readdata),
    .avs_readdatavalid (avs_readdatavalid),
    .avs_waitrequest   (avs_waitrequest),
    .key               (key),
    .vblank_set        (vblank_set),
    .vram_wr_en        (vram_wr_en),
    .vram_wr_addr      (vram_wr_addr),
    .vram_wr_data      (vram_wr_data),
    .nmi               (nmi)
  );

  always #5 clk = ~clk;

  // Every task starts and ends 1 time unit after a rising edge.
  task automatic idle();
    @(posedge clk); #1;
  endtask

  task automatic do_write(input logic [15:0] a, input logic [7:0] d);
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    @(posedge clk); #1;
    avs_write = 1'b0;
  endtask

  task automatic do_read(input logic [15:0] a, output logic [7:0] d, output logic v);
    avs_address = a; avs_read = 1'b1;
    @(posedge clk); #1;
    avs_read = 1'b0;
    d = avs_readdata; v = avs_readdatavalid;
  endtask

  task automatic test_reset();
    logic [7:0] d; logic v;
    rst = 1'b1; avs_read = 1'b1; avs_write = 1'b0; avs_address = 16'h4016;
    avs_writedata = 8'h00; key = 8'hFF; vblank_set = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (avs_readdatavalid !== 1'b0) begin n_fail++;
      $display("FAIL reset_rdv got %b want 0", avs_readdatavalid); end
    n_cmp++; if (avs_readdata !== 8'h00) begin n_fail++;
      $display("FAIL reset_rdata got %h want 00", avs_readdata); end
    n_cmp++; if ({vram_wr_en, nmi, avs_waitrequest} !== 3'b000) begin n_fail++;
      $display("FAIL reset_outs got %b want 000", {vram_wr_en, nmi, avs_waitrequest}); end
    // First cycle after reset: a strobe write here must be ignored.
    rst = 1'b0; avs_read = 1'b0;
    do_write(16'h4016, 8'h01);
    do_read(16'h4016, d, v);
    n_cmp++; if (d !== 8'h40 || v !== 1'b1) begin n_fail++;
      $display("FAIL first_idle got %h/%b want 40/1", d, v); end
  endtask

  task automatic test_ram();
    logic [7:0] d; logic v;
    do_write(16'h0123, 8'h5A);
    do_read(16'h0923, d, v);
    n_cmp++; if (d !== 8'h5A || v !== 1'b1) begin n_fail++;
      $display("FAIL ram_alias got %h/%b want 5a/1", d, v); end
    idle();
    n_cmp++; if (avs_readdatavalid !== 1'b0 || avs_readdata !== 8'h00) begin n_fail++;
      $display("FAIL ram_rdv_drop got %h/%b want 00/0", avs_readdata, avs_readdatavalid); end
    do_write(16'h1FFF, 8'hC3);
    do_read(16'h07FF, d, v);
    n_cmp++; if (d !== 8'hC3) begin n_fail++;
      $display("FAIL ram_top got %h want c3", d); end
    // Read and write together: read serviced, write dropped.
    avs_address = 16'h0123; avs_writedata = 8'hFF; avs_read = 1'b1; avs_write = 1'b1;
    @(posedge clk); #1;
    avs_read = 1'b0; avs_write = 1'b0;
    n_cmp++; if (avs_readdata !== 8'h5A || avs_readdatavalid !== 1'b1) begin n_fail++;
      $display("FAIL rw_both_read got %h want 5a", avs_readdata); end
    do_read(16'h0123, d, v);
    n_cmp++; if (d !== 8'h5A) begin n_fail++;
      $display("FAIL rw_both_nowrite got %h want 5a", d); end
  endtask

  task automatic test_vram_inc();
    logic [13:0] exp_a [3] = '{14'h2108, 14'h2109, 14'h210A};
    logic [7:0]  exp_d [3] = '{8'h11, 8'h22, 8'h33};
    do_write(16'h3FF8, 8'h00);
    do_write(16'h2006, 8'h21);
    do_write(16'h2006, 8'h08);
    for (int i = 0; i < 3; i++) begin
      do_write(16'h2007, exp_d[i]);
      n_cmp++;
      if (vram_wr_en !== 1'b1 || vram_wr_addr !== exp_a[i] || vram_wr_data !== exp_d[i]) begin
        n_fail++;
        $display("FAIL vram_inc[%0d] got %b/%h/%h want 1/%h/%h", i, vram_wr_en, vram_wr_addr,
                 vram_wr_data, exp_a[i], exp_d[i]);
      end
    end
    idle();
    n_cmp++; if (vram_wr_en !== 1'b0) begin n_fail++;
      $display("FAIL vram_pulse got %b want 0", vram_wr_en); end
  endtask

  task automatic test_vram_wrap();
    do_write(16'h2000, 8'h04);
    do_write(16'h2006, 8'h3F);
    do_write(16'h2006, 8'hF0);
    do_write(16'h2007, 8'hAA);
    n_cmp++; if (vram_wr_en !== 1'b1 || vram_wr_addr !== 14'h3FF0) begin n_fail++;
      $display("FAIL wrap_first got %b/%h want 1/3ff0", vram_wr_en, vram_wr_addr); end
    do_write(16'h2007, 8'hBB);
    n_cmp++; if (vram_wr_en !== 1'b1 || vram_wr_addr !== 14'h0010) begin n_fail++;
      $display("FAIL wrap_second got %b/%h want 1/0010", vram_wr_en, vram_wr_addr); end
  endtask

  task automatic test_toggle();
    logic [7:0] d; logic v;
    do_write(16'h2000, 8'h00);
    do_write(16'h2006, 8'h55);
    do_read(16'h2002, d, v);
    n_cmp++; if (d !== 8'h00 || v !== 1'b1) begin n_fail++;
      $display("FAIL toggle_status got %h/%b want 00/1", d, v); end
    do_write(16'h200E, 8'h12);
    do_write(16'h2006, 8'h34);
    do_write(16'h2007, 8'h77);
    n_cmp++; if (vram_wr_addr !== 14'h1234) begin n_fail++;
      $display("FAIL toggle_addr got %h want 1234", vram_wr_addr); end
  endtask

  task automatic test_vblank_nmi();
    logic [7:0] d; logic v;
    vblank_set = 1'b1; idle(); vblank_set = 1'b0;
    n_cmp++; if (nmi !== 1'b0) begin n_fail++;
      $display("FAIL nmi_masked got %b want 0", nmi); end
    do_write(16'h2000, 8'h80);
    n_cmp++; if (nmi !== 1'b1) begin n_fail++;
      $display("FAIL nmi_enable got %b want 1", nmi); end
    do_read(16'h2002, d, v);
    n_cmp++; if (d !== 8'h80 || nmi !== 1'b0) begin n_fail++;
      $display("FAIL status_first got %h/nmi %b want 80/0", d, nmi); end
    do_read(16'h200A, d, v);
    n_cmp++; if (d !== 8'h00) begin n_fail++;
      $display("FAIL status_second got %h want 00", d); end
    // vblank start coinciding with a STATUS read.
    vblank_set = 1'b1;
    do_read(16'h2002, d, v);
    vblank_set = 1'b0;
    n_cmp++; if (d !== 8'h00 || nmi !== 1'b1) begin n_fail++;
      $display("FAIL status_race got %h/nmi %b want 00/1", d, nmi); end
  endtask

  task automatic test_joypad();
    logic [7:0] d; logic v;
    logic [7:0] exp [10] = '{8'h41, 8'h40, 8'h40, 8'h41, 8'h40, 8'h40, 8'h40, 8'h40,
                             8'h41, 8'h41};
    key = 8'h09;
    do_write(16'h4016, 8'h01);
    do_write(16'h4016, 8'h00);
    key = 8'hF0;
    for (int i = 0; i < 10; i++) begin
      do_read(16'h4016, d, v);
      n_cmp++;
      if (d !== exp[i] || v !== 1'b1) begin n_fail++;
        $display("FAIL joy_read[%0d] got %h/%b want %h/1", i, d, v, exp[i]); end
    end
  endtask

  task automatic test_other();
    logic [7:0] d; logic v;
    logic [15:0] addrs [3] = '{16'h2001, 16'h4017, 16'h8000};
    do_write(16'h0000, 8'h33);
    do_write(16'h8000, 8'h99);
    do_write(16'h4017, 8'h99);
    do_read(16'h0000, d, v);
    n_cmp++; if (d !== 8'h33) begin n_fail++;
      $display("FAIL unmapped_write got %h want 33", d); end
    for (int i = 0; i < 3; i++) begin
      do_read(addrs[i], d, v);
      n_cmp++; if (d !== 8'h00 || v !== 1'b1) begin n_fail++;
        $display("FAIL unmapped_read[%0d] got %h/%b want 00/1", i, d, v); end
    end
  endtask

  task automatic test_reset_drop();
    logic [7:0] d; logic v;
    n_cmp++; if (nmi !== 1'b1) begin n_fail++;
      $display("FAIL pre_reset_nmi got %b want 1", nmi); end
    avs_address = 16'h0123; avs_read = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    avs_read = 1'b0;
    n_cmp++; if (avs_readdatavalid !== 1'b0 || nmi !== 1'b0) begin n_fail++;
      $display("FAIL reset_drop got rdv %b nmi %b want 0/0", avs_readdatavalid, nmi); end
    rst = 1'b0;
    idle();
    do_read(16'h2002, d, v);
    n_cmp++; if (d !== 8'h00 || v !== 1'b1) begin n_fail++;
      $display("FAIL post_reset_status got %h/%b want 00/1", d, v); end
  endtask

  initial begin
    test_reset();
    test_ram();
    test_vram_inc();
    test_vram_wrap();
    test_toggle();
    test_vblank_nmi();
    test_joypad();
    test_other();
    test_reset_drop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
